if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch front end of the ARM pipeline. It sits directly upstream of the decode stage and is the producer of the decode stage's `PC_in`/`instruction_in` pair. Each cycle it issues one read to a synchronous instruction memory and registers the returned word into the IF/ID register. It handles hazard freezes with a one-entry skid buffer and branch redirects with a one-cycle flush.

## Interface
- `ADDRESS_LEN`, 32, width of PC and memory address
- `INSTRUCTION_LEN`, 32, instruction width
- `RESET_PC`, 0, first fetch address after reset
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `freeze` in 1: hazard stall from hazard unit; holds IF/ID and stops issue
- `branch_taken` in 1: redirect from execute stage
- `branch_address` in ADDRESS_LEN: redirect target
- `imem_addr` out ADDRESS_LEN: read address (combinational)
- `imem_rd_en` out 1: read strobe (combinational); data returns next cycle
- `imem_rdata` in INSTRUCTION_LEN: read data, valid the cycle after `imem_rd_en`
- `PC` out ADDRESS_LEN: registered address of fetched instruction + 4
- `instruction` out INSTRUCTION_LEN: registered fetched instruction
- `valid` out 1: IF/ID register holds a real instruction

## Operation
- **State:**
  - `fetch_pc`
  - in-flight tag {`if_v`, `if_pc`}
  - skid {`sk_v`, `sk_pc`, `sk_instr`}
  - IF/ID register {`valid`, `PC`, `instruction`}
- **Issue (combinational):**
  - `imem_rd_en = rst & (branch_taken | ~freeze)`.
  - `imem_addr = branch_taken ? branch_address : fetch_pc`.
- **On issue:** `fetch_pc <= imem_addr + 4`; `if_v <= 1`; `if_pc <= imem_addr`. Otherwise `if_v <= 0` and `fetch_pc` holds.
- **Arrival:** the cycle in which `if_v=1`; the data is `imem_rdata`. The following rules are in priority order.
  1. `branch_taken`: `valid <= 0`, `instruction <= 0`, `sk_v <= 0`. The arriving word is discarded.
  2. `freeze` with arrival: IF/ID holds; `sk_v <= 1`, `sk_pc <= if_pc`, `sk_instr <= imem_rdata`.
  3. `freeze` without arrival: IF/ID and skid hold.
  4. `~freeze` with `sk_v`: IF/ID <= {1, `sk_pc+4`, `sk_instr`}, `sk_v <= 0`.
  5. `~freeze` with arrival: IF/ID <= {1, `if_pc+4`, `imem_rdata`}.
  6. `~freeze`, no arrival, no skid: `valid <= 0` (bubble). `PC` and `instruction` hold.
- **Invariant:** `sk_v` and arrival are never both 1 while `~freeze & ~branch_taken`, because no issue occurs during a freeze. The bench asserts this.
- **Arithmetic:** address + 4 is modulo 2^ADDRESS_LEN; `0xFFFFFFFC` wraps to `0`.
- `freeze` and `branch_taken` together: the branch wins (flush and redirect issue).

## Timing
- **Reset (`rst`=0, async):**
  - `fetch_pc=RESET_PC`; `if_v=0`; `sk_v=0`.
  - `valid=0`; `PC=0`; `instruction=0`.
  - `imem_rd_en=0`.
- **After reset release:** first issue in the first cycle. The first valid IF/ID appears after the 2nd rising edge. Steady-state throughput is one instruction per cycle.
- **Fetch latency:** issue at edge N-1 to N, data at edge N, IF/ID visible after edge N+1. That is 2 cycles from address to `valid`.
- **Branch penalty:**
  - Target issued in the same cycle as `branch_taken`.
  - `valid=0` for exactly one cycle.
  - Target instruction is valid in the next cycle.
- **Freeze release:** the skid word reaches IF/ID on the first unfrozen edge. The next issue happens in that same cycle, so there is no extra bubble beyond the freeze length.
- **Reset asserted mid-operation:** all state clears immediately. In-flight data is ignored because `if_v=0`.

## Test plan
- **Reset then run:** memory returns `word[a]=a`. Release reset with `freeze=0`.
  - Cycle 2: `valid=1`, `instruction=0`, `PC=4`.
  - Cycle 3: `instruction=4`, `PC=8`.
  - Every subsequent cycle is valid.
- **Freeze 3 cycles:** assert while IF/ID holds `0x8`/`PC=0xC`.
  - IF/ID holds for 3 cycles and `imem_rd_en=0`.
  - Skid captures `0xC`.
  - On release: `0xC` (`PC=0x10`), then `0x10` with no gap and no duplicate.
- **Branch to 0x100:** pulse `branch_taken` for 1 cycle.
  - `imem_addr=0x100` in that cycle.
  - Next cycle `valid=0`.
  - Following cycle `instruction=0x100`, `PC=0x104`.
  - The stale sequential word never appears.
- **Branch during freeze with skid full:** both asserted.
  - Skid is dropped and `valid=0`.
  - After `freeze` drops, the target `0x200` arrives first.
- **Wrap:** branch to `0xFFFFFFFC`. Outputs are `PC=0x0`, followed by a fetch from `0x0`.
- **Async reset mid-stream:** drop `rst` between edges.
  - All outputs go to 0 immediately.
  - After release, fetch resumes at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port of the fetch unit.
// The fetch unit is the master: it drives the address and read strobe. The
// synchronous memory is the slave and returns data one cycle after the strobe.
interface if_fetch_unit_if #(
  parameter int ADDRESS_LEN     = 32,
  parameter int INSTRUCTION_LEN = 32
);
  logic [ADDRESS_LEN-1:0]     imem_addr;
  logic                       imem_rd_en;
  logic [INSTRUCTION_LEN-1:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_rd_en,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_rd_en,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end.
// Issues one read per cycle to a synchronous instruction memory and registers
// the returned word into the IF/ID register consumed by decode. While frozen,
// a word that is already in flight is parked in a one-entry skid buffer, so
// nothing is lost or duplicated. A taken branch flushes IF/ID and the skid,
// and the branch target is issued in the same cycle.
module if_fetch_unit #(
  parameter int                     ADDRESS_LEN     = 32,
  parameter int                     INSTRUCTION_LEN = 32,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDRESS_LEN-1:0]     branch_address,
  if_fetch_unit_if.master            imem,
  output logic [ADDRESS_LEN-1:0]     PC,
  output logic [INSTRUCTION_LEN-1:0] instruction,
  output logic                       valid
);

  // Next sequential address; wraps modulo 2^ADDRESS_LEN.
  function automatic logic [ADDRESS_LEN-1:0] pc_plus4(input logic [ADDRESS_LEN-1:0] a);
    return a + ADDRESS_LEN'(4);
  endfunction

  logic [ADDRESS_LEN-1:0]     fetch_pc;
  logic                       if_v;
  logic [ADDRESS_LEN-1:0]     if_pc;
  logic                       sk_v;
  logic [ADDRESS_LEN-1:0]     sk_pc;
  logic [INSTRUCTION_LEN-1:0] sk_instr;

  logic                       issue;
  logic [ADDRESS_LEN-1:0]     issue_addr;

  // Issue decision: a branch redirect overrides a freeze; nothing issues in reset.
  always_comb begin
    issue      = rst & (branch_taken | ~freeze);
    issue_addr = branch_taken ? branch_address : fetch_pc;
  end

  assign imem.imem_rd_en = issue;
  assign imem.imem_addr  = issue_addr;

  // ---- stage 0: issue -> in-flight tag (data returns on the next edge) ----
  // Advance the fetch address and tag the read that is now in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      if_v     <= 1'b0;
      if_pc    <= '0;
    end else begin
      if_v <= issue;
      if (issue) begin
        fetch_pc <= pc_plus4(issue_addr);
        if_pc    <= issue_addr;
      end
    end
  end

  // ---- stage 1: arrival -> skid buffer / IF/ID register ----
  // Route the arriving word into IF/ID, park it in the skid while frozen, or flush on a branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid       <= 1'b0;
      PC          <= '0;
      instruction <= '0;
      sk_v        <= 1'b0;
      sk_pc       <= '0;
      sk_instr    <= '0;
    end else if (branch_taken) begin
      // The arriving word belongs to the wrong path and is dropped.
      valid       <= 1'b0;
      instruction <= '0;
      sk_v        <= 1'b0;
    end else if (freeze) begin
      // IF/ID holds; an in-flight word is kept so it is not refetched.
      if (if_v) begin
        sk_v     <= 1'b1;
        sk_pc    <= if_pc;
        sk_instr <= imem.imem_rdata;
      end
    end else if (sk_v) begin
      // Skid drains first; no arrival can coincide since nothing issued while frozen.
      valid       <= 1'b1;
      PC          <= pc_plus4(sk_pc);
      instruction <= sk_instr;
      sk_v        <= 1'b0;
    end else if (if_v) begin
      valid       <= 1'b1;
      PC          <= pc_plus4(if_pc);
      instruction <= imem.imem_rdata;
    end else begin
      // Bubble: PC and instruction keep their last values.
      valid <= 1'b0;
    end
  end

endmodule
